// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [WIDTH-1:0] DIV0_QUO = '1;

  typedef enum logic [1:0] {
    MD_MULL = 2'b00,
    MD_MULH = 2'b01,
    MD_DIV  = 2'b10,
    MD_REM  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_addsub.sv
// Single add/subtract unit shared by the multiply add step and the divide trial subtract.
module muldiv_addsub #(
  parameter int W = 17
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         sub_i,
  output logic [W-1:0] s_o
);

  assign s_o = sub_i ? (x_i - y_i) : (x_i + y_i);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 16-bit unsigned multiply/divide beside the EX-stage ALU; stalls the front end
// while iterating and pulses done for one cycle with the selected result.
import muldiv_pkg::*;

module muldiv_seq (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output md_state_e        state_dbg
);

  md_state_e        state_q;
  md_op_e           op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [WIDTH-1:0] hi_d, lo_d, addend;
  logic [WIDTH-1:0] result_q;
  logic             done_q, err_q;
  logic [WIDTH:0]   x_w, y_w, s_w;
  logic             is_div_q, sel_hi_q, accept, div0;

  // hi/lo double as rem/quo for divide.
  assign is_div_q = (op_q == MD_DIV) || (op_q == MD_REM);
  assign sel_hi_q = (op_q == MD_MULH) || (op_q == MD_REM);
  assign accept   = start & ~flush & (state_q != MD_RUN);
  assign div0     = ((md_op_e'(op) == MD_DIV) || (md_op_e'(op) == MD_REM)) && (b == '0);

  always_comb begin
    addend = (is_div_q | lo_q[0]) ? b_q : '0;
    x_w    = is_div_q ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
    y_w    = {1'b0, addend};
  end

  muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
    .x_i   (x_w),
    .y_i   (y_w),
    .sub_i (is_div_q),
    .s_o   (s_w)
  );

  // Divide restores by keeping the shifted remainder when the trial goes negative.
  always_comb begin
    hi_d = s_w[WIDTH:1];
    lo_d = {s_w[0], lo_q[WIDTH-1:1]};
    if (is_div_q) begin
      hi_d = s_w[WIDTH] ? x_w[WIDTH-1:0] : s_w[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ~s_w[WIDTH]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_MULL;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        MD_RUN: begin
          if (flush) begin
            state_q <= MD_IDLE;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q  <= MD_DONE;
              done_q   <= 1'b1;
              result_q <= sel_hi_q ? hi_d : lo_d;
            end
          end
        end
        default: begin
          if (accept) begin
            op_q  <= md_op_e'(op);
            b_q   <= b;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= a;
            if (div0) begin
              state_q  <= MD_DONE;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
              result_q <= op[0] ? a : DIV0_QUO;
            end else begin
              state_q <= MD_RUN;
            end
          end else begin
            state_q <= MD_IDLE;
          end
        end
      endcase
    end
  end

  assign stall     = ~flush & ((state_q == MD_RUN) | (start & (state_q != MD_RUN)));
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule
